// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: memory word, RAM handshake state, and the
// memory arbiter's grant state and starve-counter width.
package cpu_types_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned ARB_STARVE_W = 4;

  typedef logic [WORD_W-1:0] word_t;

  // RAM handshake as seen by the arbiter
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Owner of the shared RAM port
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares the single RAM port between instruction fetch and
// data accesses. A registered grant state selects the owner; the RAM-side
// controls and the iwait/dwait handshake decode from that state plus the live
// request and ramstate. Every ack is followed by one IDLE turnaround cycle.
//
// Ports:
//   CLK, nRST             clock, synchronous active-low reset
//   iREN, iaddr           instruction read request / address
//   iload, iwait          instruction read data / stall until serviced
//   dREN, dWEN            data read / write request (dWEN wins if both)
//   daddr, dstore         data address / write value
//   dload, dwait          data read data / stall until serviced
//   ramaddr, ramstore     RAM address / write data
//   ramREN, ramWEN        RAM read / write enable
//   ramload, ramstate     RAM read data / handshake state
//
// Parameter STARVE_MAX (1..15): data grants tolerated while a fetch waits.
// Optional macro MEM_ARB_STARVE_GUARD_EN compiles in the fetch starvation
// guard; without it data always has priority over instruction fetch.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      iwait,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dwait,
  output word_t     ramaddr,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  // Elaboration-time guard on the parameter range
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("memory_arbiter: STARVE_MAX must be in 1..15");
  end

  arb_state_t state_q, state_d;
  logic       d_req;
  logic       starve_fire;

  assign d_req = dREN | dWEN;

  // Read data is a pass-through; only meaningful in the owner's ack cycle
  assign iload = ramload;
  assign dload = ramload;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [ARB_STARVE_W-1:0] STARVE_LIM = ARB_STARVE_W'(STARVE_MAX);

  logic [ARB_STARVE_W-1:0] istarve_q, istarve_d;

  assign starve_fire = (istarve_q == STARVE_LIM);

  // Count data grants that overtake a waiting fetch, saturating at the limit
  always_comb begin
    istarve_d = istarve_q;
    if (state_q == IDLE) begin
      if (!iREN) begin
        istarve_d = '0;
      end else if (state_d == IGRANT) begin
        istarve_d = '0;
      end else if (state_d == DGRANT && istarve_q != STARVE_LIM) begin
        istarve_d = istarve_q + ARB_STARVE_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      istarve_q <= '0;
    end else begin
      istarve_q <= istarve_d;
    end
  end
`else
  assign starve_fire = 1'b0;
`endif

  // Grant state register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and RAM/handshake decode
  always_comb begin
    state_d  = state_q;
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    iwait    = 1'b1;
    dwait    = 1'b1;

    case (state_q)
      IDLE: begin
        if (d_req && !(iREN && starve_fire)) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end

      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        // A dropped request aborts without an ack even if RAM completes
        if (!d_req) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          dwait   = 1'b0;
          state_d = IDLE;
        end
      end

      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          iwait   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level owner model.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned SMAX = 2;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  word_t     iload, dload, ramaddr, ramstore;
  logic      iwait, dwait, ramREN, ramWEN;
  ramstate_t ramstate;

  always #5 CLK = ~CLK;

  memory_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramaddr(ramaddr), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 fetch, 2 data)
  int owner  = 0;
  int starve = 0;
  int n_iack = 0;
  int n_dack = 0;
  bit guard_on;

  // One clock cycle: check outputs against the model, then advance it
  task automatic tick();
    logic dreq, acc, iack, dack;
    #1;
    dreq = dREN | dWEN;
    acc  = (ramstate == ACCESS);
    iack = (owner == 1) && iREN && acc;
    dack = (owner == 2) && dreq && acc;
    case (owner)
      1: begin
        check_eq("i_ramaddr", ramaddr, iaddr);
        check_eq("i_ramREN", 32'(ramREN), 32'(iREN));
        check_eq("i_ramWEN", 32'(ramWEN), 32'd0);
      end
      2: begin
        check_eq("d_ramaddr", ramaddr, daddr);
        check_eq("d_ramstore", ramstore, dstore);
        check_eq("d_ramWEN", 32'(ramWEN), 32'(dWEN));
        check_eq("d_ramREN", 32'(ramREN), 32'(dREN && !dWEN));
      end
      default: begin
        check_eq("idle_ramaddr", ramaddr, 32'd0);
        check_eq("idle_ramstore", ramstore, 32'd0);
        check_eq("idle_enables", {30'd0, ramREN, ramWEN}, 32'd0);
      end
    endcase
    check_eq("iwait", 32'(iwait), 32'(!iack));
    check_eq("dwait", 32'(dwait), 32'(!dack));
    if (iack) check_eq("iload", iload, ramload);
    if (dack) check_eq("dload", dload, ramload);
    if (iack) n_iack++;
    if (dack) n_dack++;

    @(posedge CLK);
    if (!nRST) begin
      owner  = 0;
      starve = 0;
    end else if (owner == 0) begin
      if (!iREN) starve = 0;
      if (dreq && !(iREN && guard_on && starve == int'(SMAX))) begin
        owner = 2;
        if (iREN && starve < int'(SMAX)) starve++;
      end else if (iREN) begin
        owner  = 1;
        starve = 0;
      end
    end else if (owner == 1) begin
      if (!iREN || acc) owner = 0;
    end else begin
      if (!dreq || acc) owner = 0;
    end
    @(negedge CLK);
  endtask

  task automatic drive(input logic ir, input logic dr, input logic dw, input ramstate_t rs);
    iREN = ir; dREN = dr; dWEN = dw; ramstate = rs;
  endtask

  int base_iack;

  initial begin
`ifdef MEM_ARB_STARVE_GUARD_EN
    guard_on = 1'b1;
`else
    guard_on = 1'b0;
`endif
    nRST = 1'b0;
    iaddr = '0; daddr = 32'h0000_0080; dstore = '0; ramload = '0;
    drive(1'b0, 1'b0, 1'b0, FREE);
    @(negedge CLK);

    // Reset held with both requests, then release into a data grant
    drive(1'b1, 1'b1, 1'b0, BUSY);
    tick();
    tick();
    nRST = 1'b1;
    tick();
    #1;
    check_eq("rst_release_dgrant", {ramREN, ramaddr == daddr}, 32'd3);
    drive(1'b0, 1'b0, 1'b0, FREE);
    tick();
    tick();

    // Lone fetch: BUSY twice then ACCESS
    iaddr = 32'h40;
    drive(1'b1, 1'b0, 1'b0, BUSY);
    tick();
    tick();
    tick();
    ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
    #1;
    check_eq("ifetch_iwait", 32'(iwait), 32'd0);
    check_eq("ifetch_iload", iload, 32'hDEAD_BEEF);
    check_eq("ifetch_addr", ramaddr, 32'h40);
    tick();
    drive(1'b0, 1'b0, 1'b0, FREE);
    tick();

    // Write wins over a pending fetch; fetch follows after turnaround
    daddr = 32'h100; dstore = 32'h1234_5678;
    drive(1'b1, 1'b0, 1'b1, ACCESS);
    tick();
    #1;
    check_eq("wr_ramWEN", 32'(ramWEN), 32'd1);
    check_eq("wr_addr", ramaddr, 32'h100);
    check_eq("wr_data", ramstore, 32'h1234_5678);
    check_eq("wr_dwait", 32'(dwait), 32'd0);
    tick();
    dWEN = 1'b0;
    tick();
    #1;
    check_eq("wr_then_ifetch", {ramREN, ramaddr == iaddr}, 32'd3);
    tick();
    drive(1'b0, 1'b0, 1'b0, FREE);
    tick();

    // Abort: data read dropped before ACCESS
    drive(1'b0, 1'b1, 1'b0, BUSY);
    tick();
    tick();
    dREN = 1'b0;
    #1;
    check_eq("abort_ramREN", 32'(ramREN), 32'd0);
    check_eq("abort_dwait", 32'(dwait), 32'd1);
    tick();
    #1;
    check_eq("abort_idle_addr", ramaddr, 32'd0);
    tick();

    // Continuous competing traffic: fetch acks only with the guard on
    daddr = 32'h200; iaddr = 32'h300;
    base_iack = n_iack;
    drive(1'b1, 1'b1, 1'b0, ACCESS);
    for (int i = 0; i < 12; i++) tick();
    check_eq("starve_iacks", 32'(n_iack - base_iack), guard_on ? 32'd2 : 32'd0);
    drive(1'b0, 1'b0, 1'b0, FREE);
    tick();
    tick();

    // ERROR retried while fetch holds the grant
    iaddr = 32'h44;
    drive(1'b1, 1'b0, 1'b0, FREE);
    tick();
    ramstate = ERROR;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("err_ramREN", 32'(ramREN), 32'd1);
      check_eq("err_iwait", 32'(iwait), 32'd1);
      tick();
    end
    ramstate = ACCESS; ramload = 32'hCAFE_F00D;
    #1;
    check_eq("err_ack", {31'd0, iwait}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, FREE);
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      nRST    = ($urandom_range(0, 80) != 0);
      iREN    = ($urandom_range(0, 3) != 0);
      dREN    = ($urandom_range(0, 2) == 0);
      dWEN    = ($urandom_range(0, 4) == 0);
      iaddr   = $urandom;
      daddr   = $urandom;
      dstore  = $urandom;
      ramload = $urandom;
      ramstate = ($urandom_range(0, 2) == 0) ? ACCESS
                                             : ramstate_t'(2'($urandom_range(0, 3)));
      tick();
    end
    check_eq("rand_dacks_seen", 32'(n_dack > 50), 32'd1);
    check_eq("rand_iacks_seen", 32'(n_iack > 50), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Arbitrates the single shared RAM port between the instruction-fetch requester (icache side) and the data requester (dcache side). It sits between the pipeline's memory interfaces and the RAM model, below the hazard unit. The hazard unit consumes `iwait`/`dwait` to generate stalls. A registered grant FSM serialises accesses and returns the RAM handshake to the owning requester. An optional starvation guard bounds instruction-fetch latency under back-to-back data traffic.

## Interface
Parameters:
- `STARVE_MAX`, default 4: consecutive dcache grants given while an ifetch waits before ifetch is forced to win. Legal range 1..15.

Ports:
- `CLK`  in  1  single clock; all state updates on rising edge
- `nRST`  in  1  reset, synchronous, active-low
- `iREN`  in  1  instruction read request
- `iaddr`  in  32  instruction address (word_t)
- `iload`  out  32  instruction read data
- `iwait`  out  1  high until ifetch is serviced
- `dREN`  in  1  data read request
- `dWEN`  in  1  data write request
- `daddr`  in  32  data address
- `dstore`  in  32  data write value
- `dload`  out  32  data read data
- `dwait`  out  1  high until data access is serviced
- `ramaddr`  out  32  RAM address
- `ramREN`  out  1  RAM read enable
- `ramWEN`  out  1  RAM write enable
- `ramstore`  out  32  RAM write data
- `ramload`  in  32  RAM read data
- `ramstate`  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

## Operation
- FSM states: IDLE, IGRANT, DGRANT.
- IDLE: RAM enables low, `ramaddr`/`ramstore` = 0, `iwait` = `dwait` = 1.
  - Data request (`dREN|dWEN`) present → DGRANT.
  - Else `iREN` present → IGRANT.
  - Both present: DGRANT, unless the starve guard fires, then IGRANT.
- DGRANT: `ramaddr`=`daddr`, `ramstore`=`dstore`, `ramWEN`=`dWEN`, `ramREN`=`dREN & ~dWEN`.
  - `dWEN` wins if both are high; that request combination is illegal.
  - `ramstate==ACCESS` → `dwait`=0 that cycle, `dload`=`ramload`, next state IDLE.
- IGRANT: `ramaddr`=`iaddr`, `ramREN`=1, `ramWEN`=0.
  - `ramstate==ACCESS` → `iwait`=0, `iload`=`ramload`, next state IDLE.
- `ramstate` BUSY/FREE/ERROR while granted: hold the grant, keep wait high. ERROR is retried by holding the enables.
- Owner drops its request while granted (abort): next state IDLE, no ack. RAM enables follow the live request in the abort cycle.
- `iload`/`dload` are combinational pass-throughs of `ramload`; they are valid only in their ack cycle.
- Non-owner wait is always 1.

## Timing
- All RAM-side outputs and waits decode from the state register plus live request/`ramstate`. No output is registered beyond the state.
- Minimum latency is 2 cycles: request seen in IDLE (cycle 0), grant plus ACCESS in cycle 1, ack in cycle 1.
- There is one mandatory IDLE turnaround cycle after every ack. Back-to-back service of the same requester therefore takes at least 2 cycles per access.
- Reset (`nRST`=0 at an edge), including mid-grant: state IDLE, starve counter 0. From the next cycle all RAM enables are 0 and both waits are 1.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined: a 4-bit counter `istarve` is compiled in.
  - Increments on each DGRANT entry taken while `iREN` is high.
  - Clears on IGRANT entry or when `iREN` is low in IDLE.
  - Saturates at `STARVE_MAX`.
  - When `istarve==STARVE_MAX` in IDLE with both requests present, IGRANT is taken.
- Undefined: strict dcache priority. No counter exists and ifetch can starve indefinitely.

## Structure
- `cpu_types_pkg`: `word_t` and `ramstate_t` (existing).
- `cpu_types_pkg`: new `arb_state_t` enum {IDLE, IGRANT, DGRANT} and constant `ARB_STARVE_W = 4`.
- Single module, no sub-module. The optional starve counter is inline under the macro.

## Test plan
- Reset: hold `nRST`=0 two cycles with `iREN`=`dREN`=1 → `ramREN`=`ramWEN`=0, `iwait`=`dwait`=1; release → DGRANT next cycle.
- Lone ifetch: `iREN`=1, `iaddr`=0x40, RAM BUSY 2 cycles then ACCESS with `ramload`=0xDEADBEEF → `ramaddr`=0x40. `iwait` falls exactly in the ACCESS cycle, `iload`=0xDEADBEEF, then IDLE.
- Write priority: `iREN` and `dWEN` both high, `daddr`=0x100, `dstore`=0x12345678 → `ramWEN`=1 with that address and data first, `dwait` low on ACCESS; IGRANT follows after one IDLE cycle.
- Abort: in DGRANT drop `dREN` before ACCESS → next cycle IDLE, `ramREN`=0, no `dwait` low pulse.
- Starve guard (macro on, `STARVE_MAX`=2): continuous `dREN` plus `iREN`, RAM ACCESS every grant → the sequence is D, D, I, D, D, I… With the macro off the sequence is D only and `iwait` stays 1.
- ERROR retry: in IGRANT drive ERROR for 3 cycles then ACCESS → `ramREN` held high throughout, `iwait` low only in the ACCESS cycle.
